// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the sequential radix-4 Booth multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_t;
  function automatic int n_iter(input int n);
    return n / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: radix-4 Booth digit decode and W-bit partial product (d * m)
// Ports: bits = Booth window Q[2:0], m = sign/zero-extended multiplicand, pp = d*m mod 2^W
module booth_r4_encoder
  import mult_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   bits,
  input  logic [W-1:0] m,
  output logic [W-1:0] pp
);
  booth_digit_t d;
  always_comb begin
    case (bits)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    pp = d == P1 ? m :
         d == P2 ? m << 1 :
         d == M1 ? -m :
         d == M2 ? -(m << 1) : '0;
  end
endmodule

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: iterative radix-4 Booth multiplier, signed/unsigned per operation
// Ports: clk, rst (sync, active-high); in_valid/in_ready with signed_mode, multiplicand,
//        multiplier capture an operation; out_valid/out_ready hand back the 2N-bit product.
// Build option: EARLY_TERM_EN finishes CALC once the remaining Booth digits are all zero.
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int parallelism = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       signed_mode,
  input  logic [parallelism-1:0]     multiplicand,
  input  logic [parallelism-1:0]     multiplier,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*parallelism-1:0]   product
);
  localparam int N  = parallelism;
  localparam int K  = n_iter(N);
  localparam int CW = $clog2(K);
  state_t         state_q, state_d;
  logic [N+2:0]   q_q, q_d, q_sh;
  logic [2*N-1:0] m_q, m_d, acc_q, acc_d, product_q, product_d, pp, acc_nx;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sa, sb, last, accept;
  booth_r4_encoder #(.W(2*N)) u_enc (
    .bits (q_q[2:0]),
    .m    (m_q),
    .pp   (pp)
  );
  assign sa       = signed_mode & multiplicand[N-1];
  assign sb       = signed_mode & multiplier[N-1];
  assign q_sh     = {q_q[N+2], q_q[N+2], q_q[N+2:2]};
  assign acc_nx   = acc_q + (pp << {cnt_q, 1'b0});
  assign in_ready = ~rst & (state_q == IDLE | (state_q == DONE & out_ready));
  assign accept   = in_valid & in_ready;
  assign out_valid = state_q == DONE;
  assign product   = product_q;
`ifdef EARLY_TERM_EN
  // An all-zero or all-one window can only yield zero digits from here on.
  assign last = (cnt_q == CW'(K-1)) | (&q_sh) | ~(|q_sh);
`else
  assign last = cnt_q == CW'(K-1);
`endif
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    m_d       = m_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      state_d = CALC;
      q_d     = {sb, sb, multiplier, 1'b0};
      m_d     = {{N{sa}}, multiplicand};
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == CALC) begin
      acc_d = acc_nx;
      q_d   = q_sh;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d   = DONE;
        product_d = acc_nx;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed table, handshake corner cases and random sweep vs arithmetic model
module tb_seq_booth_multiplier;
  localparam int N = 8;
  localparam int K = N / 2 + 1;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, signed_mode = 0, out_valid, out_ready = 1;
  logic [N-1:0] multiplicand = 0, multiplier = 0;
  logic [2*N-1:0] product;
  int checks = 0, errors = 0;

  seq_booth_multiplier #(.parallelism(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .multiplicand(multiplicand), .multiplier(multiplier),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           sm;
    logic [2*N-1:0] exp;
    int             lat_et;
  } vec_t;

  function automatic logic [2*N-1:0] golden(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    return (2*N)'(sa * sb);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        output int lat, output logic [2*N-1:0] p);
    int n = 0;
    @(negedge clk);
    in_valid = 1; multiplicand = a; multiplier = b; signed_mode = s; out_ready = 1;
    #1;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; multiplicand = ~a; multiplier = ~b; signed_mode = ~s;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    p = product;
  endtask

  vec_t tbl[11];
  logic [2*N-1:0] q[$];
  logic [2*N-1:0] held, p;
  int lat;

  initial begin
    tbl[0]  = '{8'h11, 8'h11, 1'b0, 16'h0121, 0};
    tbl[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 0};
    tbl[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 0};
    tbl[3]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81, 0};
    tbl[4]  = '{8'hC8, 8'h01, 1'b0, 16'h00C8, 1};
    tbl[5]  = '{8'h03, 8'hFF, 1'b1, 16'hFFFD, 1};
    tbl[6]  = '{8'h01, 8'hC0, 1'b0, 16'h00C0, 5};
    tbl[7]  = '{8'h00, 8'h00, 1'b0, 16'h0000, 1};
    tbl[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 0};
    tbl[9]  = '{8'h80, 8'h7F, 1'b1, 16'hC080, 0};
    tbl[10] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 0};

    rst = 1;
    @(negedge clk); #1;
    check("in_ready_in_reset", in_ready, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 0);
    check("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sm, lat, p);
      check($sformatf("vec%0d_product", i), p, tbl[i].exp);
      check($sformatf("vec%0d_model", i), p, golden(tbl[i].a, tbl[i].b, tbl[i].sm));
`ifdef EARLY_TERM_EN
      if (tbl[i].lat_et != 0) check($sformatf("vec%0d_latency", i), lat, tbl[i].lat_et);
      else check($sformatf("vec%0d_latency_range", i), (lat >= 1 && lat <= K), 1);
`else
      check($sformatf("vec%0d_latency", i), lat, K);
`endif
    end

    // backpressure: hold DONE, then back-to-back accept on the releasing edge
    @(negedge clk);
    out_ready = 0; in_valid = 1; multiplicand = 8'h12; multiplier = 8'h34; signed_mode = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    held = product;
    check("bp_first_product", held, 16'h03A8);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      check("bp_out_valid_stable", out_valid, 1);
      check("bp_product_stable", product, held);
      check("bp_in_ready_low", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1; in_valid = 1; multiplicand = 8'd3; multiplier = 8'd4; signed_mode = 0;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; multiplicand = 8'hAA; multiplier = 8'h55;
    check("bp_b2b_in_calc", out_valid, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    check("bp_b2b_product", product, 16'h000C);

    // reset two edges into CALC
    @(negedge clk);
    in_valid = 1; multiplicand = 8'h55; multiplier = 8'h66; signed_mode = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_product", product, 0);
    check("rst_mid_in_ready_after", in_ready, 1);
    run_op(8'd5, 8'd6, 1'b0, lat, p);
    check("rst_then_5x6", p, 16'h001E);

    // random sweep with random in_valid/out_ready gaps, scoreboard against golden product
    begin
      int accepted = 0, cyc = 0;
      while ((accepted < 2000 || q.size() != 0) && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        in_valid = accepted < 2000 && $urandom_range(3) != 0;
        multiplicand = N'($urandom);
        multiplier = N'($urandom);
        signed_mode = 1'($urandom);
        out_ready = $urandom_range(3) != 0;
        #1;
        if (out_valid && out_ready) begin
          if (q.size() == 0) check("rand_unexpected_output", 1, 0);
          else check("rand_product", product, q.pop_front());
        end
        if (in_valid && in_ready) begin
          q.push_back(golden(multiplicand, multiplier, signed_mode));
          accepted++;
        end
      end
      check("rand_all_accepted", accepted, 2000);
      check("rand_scoreboard_drained", q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
